// File: rtl/masked_serial_incrementer.sv
// Bit-serial, first-order masked incrementer: S = A + c over W cycles using a
// single masked half adder that is time-shared across all bit positions.
module half_adder_masked (
  input  logic a0,
  input  logic a1,
  input  logic b0,
  input  logic b1,
  input  logic rn,
  output logic s0,
  output logic s1,
  output logic c0,
  output logic c1
);
  // Sum is linear and stays share-wise; the AND cross terms are refreshed by rn
  // so that neither carry share depends on both shares of one operand unmasked.
  assign s0 = a0 ^ b0;
  assign s1 = a1 ^ b1;
  assign c0 = (a0 & b0) ^ ((a0 & b1) ^ rn);
  assign c1 = (a1 & b1) ^ ((a1 & b0) ^ rn);
endmodule

module masked_serial_incrementer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic [W-1:0] i_A0,
  input  logic [W-1:0] i_A1,
  input  logic         i_c0,
  input  logic         i_c1,
  input  logic         rN,
  output logic         o_ready,
  output logic         o_rnd_req,
  output logic [W-1:0] o_S0,
  output logic [W-1:0] o_S1,
  output logic         o_C0,
  output logic         o_C1,
  output logic         o_valid
);
  localparam int KW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  cap_a0, cap_a1;
  logic [W-1:0]  res0, res1;
  logic          carry0, carry1;
  logic          out_c0, out_c1;
  logic [KW-1:0] idx;
  logic          last;
  logic          g_s0, g_s1, g_c0, g_c1;

  assign last = (idx == KW'(W - 1));

  half_adder_masked u_ha (
    .a0 (cap_a0[idx]),
    .a1 (cap_a1[idx]),
    .b0 (carry0),
    .b1 (carry1),
    .rn (rN),
    .s0 (g_s0),
    .s1 (g_s1),
    .c0 (g_c0),
    .c1 (g_c1)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cap_a0 <= '0;
      cap_a1 <= '0;
      res0   <= '0;
      res1   <= '0;
      carry0 <= 1'b0;
      carry1 <= 1'b0;
      out_c0 <= 1'b0;
      out_c1 <= 1'b0;
      idx    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (i_start) begin
          cap_a0 <= i_A0;
          cap_a1 <= i_A1;
          carry0 <= i_c0;
          carry1 <= i_c1;
          idx    <= '0;
        end
        RUN: begin
          res0[idx] <= g_s0;
          res1[idx] <= g_s1;
          carry0    <= g_c0;
          carry1    <= g_c1;
          // Carry-out gets its own register so the published shares are not
          // disturbed when the next operation loads the working carry.
          if (last) begin
            out_c0 <= g_c0;
            out_c1 <= g_c1;
            idx    <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ready   = (state == IDLE);
  assign o_rnd_req = (state == RUN);
  assign o_valid   = (state == DONE);
  assign o_S0      = res0;
  assign o_S1      = res1;
  assign o_C0      = out_c0;
  assign o_C1      = out_c1;
endmodule

// File: tb/tb_masked_serial_incrementer.sv
// Randomized self-checking bench: unmasked results compared against (A+c) mod 2^W.
module tb_masked_serial_incrementer;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       start = 0;
  logic [7:0] a0 = 0, a1 = 0;
  logic       c0 = 0, c1 = 0;
  logic       rn = 0;
  logic       ready, rnd_req, valid, oc0, oc1;
  logic [7:0] s0, s1;

  logic       start2 = 0;
  logic [1:0] b0 = 0, b1 = 0;
  logic       d0 = 0, d1 = 0;
  logic       ready2, rnd_req2, valid2, oc0_2, oc1_2;
  logic [1:0] s0_2, s1_2;

  int errors = 0;
  int checks = 0;
  logic [7:0] last_s0;

  always #5 clk = ~clk;
  always @(negedge clk) rn = 1'($urandom_range(0, 1));

  masked_serial_incrementer #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_A0(a0), .i_A1(a1),
    .i_c0(c0), .i_c1(c1), .rN(rn), .o_ready(ready), .o_rnd_req(rnd_req),
    .o_S0(s0), .o_S1(s1), .o_C0(oc0), .o_C1(oc1), .o_valid(valid)
  );

  masked_serial_incrementer #(.W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_start(start2), .i_A0(b0), .i_A1(b1),
    .i_c0(d0), .i_c1(d1), .rN(rn), .o_ready(ready2), .o_rnd_req(rnd_req2),
    .o_S0(s0_2), .o_S1(s1_2), .o_C0(oc0_2), .o_C1(oc1_2), .o_valid(valid2)
  );

  // One full operation on the W=8 instance, with model-derived expectations.
  task automatic run_op(input logic [7:0] x0, input logic [7:0] x1,
                        input logic y0, input logic y1, input string nm);
    int lat, rq, sum;
    logic [7:0] exp_s;
    logic exp_c;
    sum   = int'(x0 ^ x1) + int'(y0 ^ y1);
    exp_s = 8'(sum % 256);
    exp_c = (sum >= 256);
    @(negedge clk);
    a0 = x0; a1 = x1; c0 = y0; c1 = y1; start = 1;
    @(negedge clk);
    start = 0;
    a0 = 8'($urandom); a1 = 8'($urandom); c0 = 1'($urandom); c1 = 1'($urandom);
    lat = 1; rq = 0;
    while (!valid && lat < 40) begin
      if (rnd_req) rq++;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL %s latency: got %0d expected 9", nm, lat); end
    checks++;
    if (rq !== 8) begin errors++; $display("FAIL %s rnd_req cycles: got %0d expected 8", nm, rq); end
    checks++;
    if ((s0 ^ s1) !== exp_s) begin errors++; $display("FAIL %s result: got %0h expected %0h", nm, s0 ^ s1, exp_s); end
    checks++;
    if ((oc0 ^ oc1) !== exp_c) begin errors++; $display("FAIL %s carry: got %0b expected %0b", nm, oc0 ^ oc1, exp_c); end
    last_s0 = s0;
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || ready !== 1'b1 || (s0 ^ s1) !== exp_s || (oc0 ^ oc1) !== exp_c) begin
      errors++;
      $display("FAIL %s after-done: valid=%0b ready=%0b res=%0h expected valid=0 ready=1 res=%0h",
               nm, valid, ready, s0 ^ s1, exp_s);
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ready, valid, rnd_req} !== 3'b100 || s0 !== 0 || s1 !== 0 || oc0 !== 0 || oc1 !== 0) begin
      errors++;
      $display("FAIL reset: ready/valid/rnd=%b s0=%0h s1=%0h c=%b%b expected 100 and zeros",
               {ready, valid, rnd_req}, s0, s1, oc0, oc1);
    end
    checks++;
    if ({ready2, valid2, rnd_req2} !== 3'b100 || s0_2 !== 0 || s1_2 !== 0) begin
      errors++;
      $display("FAIL reset_w2: ready/valid/rnd=%b s0=%0h s1=%0h expected 100 and zeros",
               {ready2, valid2, rnd_req2}, s0_2, s1_2);
    end
    rst_n = 1;
  endtask

  task automatic test_directed;
    run_op(8'h5A, 8'hA5, 1'b1, 1'b0, "all_ones_plus1");
    run_op(8'h3C, 8'h00, 1'b1, 1'b1, "c_zero");
    run_op(8'h00, 8'h00, 1'b0, 1'b0, "zero");
  endtask

  task automatic test_random;
    int distinct;
    logic [7:0] first_s0;
    for (int i = 0; i < 1000; i++)
      run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), "random");
    distinct = 0;
    run_op(8'h5A, 8'hA5, 1'b1, 1'b0, "mask_var");
    first_s0 = last_s0;
    for (int i = 0; i < 20; i++) begin
      run_op(8'h5A, 8'hA5, 1'b1, 1'b0, "mask_var");
      if (last_s0 !== first_s0) distinct++;
    end
    checks++;
    if (distinct == 0) begin errors++; $display("FAIL share_variation: got %0d differing runs expected >0", distinct); end
  endtask

  task automatic test_ignore;
    int lat, nvalid;
    @(negedge clk);
    a0 = 8'h10; a1 = 8'h00; c0 = 1; c1 = 0; start = 1;
    @(negedge clk);
    start = 0; lat = 1; nvalid = 0;
    while (lat < 9) begin
      if (valid) nvalid++;
      start = (lat == 3);
      if (lat == 3) begin a0 = 8'hEE; c0 = 0; end
      @(negedge clk);
      lat++;
    end
    start = 0;
    checks++;
    if (valid !== 1'b1 || nvalid !== 0 || (s0 ^ s1) !== 8'h11) begin
      errors++;
      $display("FAIL ignore_run: valid=%0b early=%0d res=%0h expected 1 0 11", valid, nvalid, s0 ^ s1);
    end
    a0 = 8'h77; a1 = 8'h00; c0 = 1; c1 = 0; start = 1;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || rnd_req !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL ignore_done: ready=%0b rnd=%0b valid=%0b expected 1 0 0", ready, rnd_req, valid);
    end
    @(negedge clk);
    start = 0; lat = 1;
    while (!valid && lat < 40) begin @(negedge clk); lat++; end
    checks++;
    if (lat !== 9 || (s0 ^ s1) !== 8'h78 || (oc0 ^ oc1) !== 1'b0) begin
      errors++;
      $display("FAIL accept_after_done: lat=%0d res=%0h expected lat=9 res=78", lat, s0 ^ s1);
    end
  endtask

  task automatic test_reset_mid;
    int nvalid;
    @(negedge clk);
    a0 = 8'hFF; a1 = 8'h00; c0 = 1; c1 = 0; start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    rst_n = 0; start = 1; a0 = 8'h55;
    @(negedge clk);
    checks++;
    if ({ready, valid, rnd_req} !== 3'b100 || s0 !== 0 || s1 !== 0 || oc0 !== 0 || oc1 !== 0) begin
      errors++;
      $display("FAIL reset_mid: ready/valid/rnd=%b s0=%0h s1=%0h c=%b%b expected 100 and zeros",
               {ready, valid, rnd_req}, s0, s1, oc0, oc1);
    end
    rst_n = 1; start = 0;
    nvalid = 0;
    repeat (12) begin @(negedge clk); if (valid || !ready) nvalid++; end
    checks++;
    if (nvalid !== 0) begin errors++; $display("FAIL reset_abort: got %0d busy/valid cycles expected 0", nvalid); end
    run_op(8'h01, 8'h00, 1'b1, 1'b0, "after_reset");
  endtask

  task automatic test_w2;
    int lat;
    for (int t = 0; t < 12; t++) begin
      logic [1:0] x0, x1;
      logic y0, y1;
      int sum;
      x0 = (t == 0) ? 2'b01 : 2'($urandom);
      x1 = (t == 0) ? 2'b10 : 2'($urandom);
      y0 = (t == 0) ? 1'b1 : 1'($urandom);
      y1 = (t == 0) ? 1'b0 : 1'($urandom);
      sum = int'(x0 ^ x1) + int'(y0 ^ y1);
      @(negedge clk);
      b0 = x0; b1 = x1; d0 = y0; d1 = y1; start2 = 1;
      @(negedge clk);
      start2 = 0; b0 = 2'($urandom); b1 = 2'($urandom);
      lat = 1;
      while (!valid2 && lat < 20) begin @(negedge clk); lat++; end
      checks++;
      if (lat !== 3 || (s0_2 ^ s1_2) !== 2'(sum % 4) || (oc0_2 ^ oc1_2) !== (sum >= 4)) begin
        errors++;
        $display("FAIL w2 op%0d: lat=%0d res=%0h carry=%0b expected lat=3 res=%0h carry=%0b",
                 t, lat, s0_2 ^ s1_2, oc0_2 ^ oc1_2, sum % 4, sum >= 4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore();
    test_reset_mid();
    test_w2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/masked_serial_incrementer.md
MASKED_SERIAL_INCREMENTER -- requirements
Module: masked_serial_incrementer

Interface
REQ-001 Parameter W, default 8: operand width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 i_start  input  1  request to begin an operation; accepted only when o_ready=1.
REQ-005 i_A0  input  W  operand share 0; operand A = i_A0 ^ i_A1.
REQ-006 i_A1  input  W  operand share 1.
REQ-007 i_c0  input  1  addend bit share 0; addend c = i_c0 ^ i_c1.
REQ-008 i_c1  input  1  addend bit share 1.
REQ-009 rN  input  1  fresh random bit; one new bit consumed per RUN cycle.
REQ-010 o_ready  output  1  high in IDLE only.
REQ-011 o_rnd_req  output  1  high exactly in cycles where rN is consumed (RUN).
REQ-012 o_S0  output  W  result share 0; result = (A + c) mod 2^W = o_S0 ^ o_S1.
REQ-013 o_S1  output  W  result share 1.
REQ-014 o_C0  output  1  carry-out share 0; carry-out = o_C0 ^ o_C1.
REQ-015 o_C1  output  1  carry-out share 1.
REQ-016 o_valid  output  1  one-cycle pulse when o_S*/o_C* hold a new result.

Function
REQ-017 Block SHALL contain exactly one half_adder_masked instance, time-shared across all W bit positions.
REQ-018 FSM states SHALL be IDLE, RUN, DONE; encoding free.
REQ-019 IDLE: i_start=1 -> capture i_A0, i_A1 into separate share registers; carry registers <= (i_c0, i_c1); bit index <= 0; next state RUN.
REQ-020 IDLE with i_start=0 SHALL stay in IDLE with all registers unchanged.
REQ-021 RUN, per cycle at index k: gadget inputs A0=capA0[k], A1=capA1[k], B0=carry0, B1=carry1, rN=rN.
REQ-022 RUN, per cycle: result share registers bit k <= gadget S0/S1; carry registers <= gadget C0/C1; k <= k+1.
REQ-023 RUN at k=W-1: after the update, carry registers become o_C0/o_C1; next state DONE; k SHALL not wrap to an out-of-range value.
REQ-024 DONE: o_valid=1 for exactly this one cycle; next state IDLE unconditionally.
REQ-025 Latency: i_start sampled at edge t -> o_valid high in the cycle after edge t+W (W RUN cycles, 1 DONE cycle); throughput one op per W+2 cycles.
REQ-026 o_S0/o_S1/o_C0/o_C1 SHALL be register outputs, stable from DONE until the next accepted operation's first RUN update.
REQ-027 i_start while o_ready=0 SHALL be ignored and not queued.
REQ-028 i_start asserted in the DONE cycle SHALL be ignored; i_start in the following IDLE cycle SHALL be accepted.
REQ-029 Inputs i_A*, i_c* SHALL be sampled only at acceptance; later changes SHALL not affect the result.
REQ-030 Masking: no wire or register SHALL combine share 0 and share 1 of the same value outside the gadget; share-0 and share-1 paths SHALL stay in separate registers.
REQ-031 Gadget outputs SHALL be registered before any further logic (glitch isolation).
REQ-032 o_rnd_req SHALL be a registered/state-decoded signal equal to (state==RUN).

Reset
REQ-033 rst_n=0 at a rising edge SHALL force IDLE, o_ready=1, o_valid=0, o_rnd_req=0, index=0, and clear all share, carry and output registers to 0.
REQ-034 Reset mid-RUN or in DONE SHALL abort the operation with no o_valid pulse; first i_start after rst_n=1 SHALL be accepted normally.
REQ-035 i_start sampled while rst_n=0 SHALL be ignored.

Verification
REQ-036 W=8, A0=0x5A, A1=0xA5 (A=0xFF), c0=1, c1=0 -> o_valid after 9 cycles, S0^S1=0x00, C0^C1=1.
REQ-037 W=8, A0=0x3C, A1=0x00, c0=1, c1=1 (c=0) -> S0^S1=0x3C, C0^C1=0; o_rnd_req high exactly 8 cycles.
REQ-038 Random shares/rN, 1000 ops -> unmasked result always (A+c) mod 256 with correct carry; shares vary with rN.
REQ-039 i_start pulsed at RUN cycle 3 and in DONE -> ignored; single o_valid for first op; next IDLE start accepted.
REQ-040 rst_n=0 at RUN cycle 4 -> next cycle IDLE, all outputs 0, no o_valid; new op A=0x01, c=1 then yields 0x02, carry 0.
REQ-041 W=2, A=0x3, c=1 -> result 0x0, carry-out 1, o_valid 3 cycles after start.
